// File: rtl/ebpc_stream_merger.sv
// ebpc_stream_merger: buffers the ZNZ and BPC encoder streams in two FIFOs and
// merges them into one stream of headed bursts {sel, fin, len-1} + payload.
// Stream index 0 is ZNZ, 1 is BPC throughout.
module ebpc_stream_merger #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] znz_data_i,
    input  logic              znz_last_i,
    input  logic              znz_vld_i,
    output logic              znz_rdy_o,
    input  logic [DATA_W-1:0] bpc_data_i,
    input  logic              bpc_last_i,
    input  logic              bpc_vld_i,
    output logic              bpc_rdy_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              vld_o,
    input  logic              rdy_i,
    output logic              idle_o
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned LW = DATA_W - 2;
    localparam logic [CW-1:0] BL_C    = CW'(BURST_LEN);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_MAX = AW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {ARB, HDR, DATA} state_e;

    logic [1:0][DATA_W-1:0] in_data;
    logic [1:0]             in_last, in_vld, rdy, push, pop, elig;
    logic [DATA_W:0]        mem_q [2][FIFO_DEPTH];
    logic [1:0][AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0][CW-1:0]     cnt_q, cnt_d;
    logic [1:0]             closed_q, closed_d, done_q, done_d;
    state_e                 state_q, state_d;
    logic                   sel_q, sel_d, fin_q, fin_d, rr_q, rr_d, pick;
    logic [CW-1:0]          len_q, len_d, beat_q, beat_d;
    logic [DATA_W:0]        head;
    logic [LW-1:0]          hdr_len;
    logic                   burst_end, frame_end;

    assign in_data   = {bpc_data_i, znz_data_i};
    assign in_last   = {bpc_last_i, znz_last_i};
    assign in_vld    = {bpc_vld_i, znz_vld_i};
    assign znz_rdy_o = rdy[0];
    assign bpc_rdy_o = rdy[1];

    // Head of the selected FIFO; its stored last flag marks the stream's final word.
    assign head      = mem_q[sel_q][rptr_q[sel_q]];
    assign hdr_len   = LW'(len_q - CW'(1));
    assign pop       = {2{state_q == DATA && rdy_i}} & (sel_q ? 2'b10 : 2'b01);
    assign burst_end = (state_q == DATA) && rdy_i && (beat_q == CW'(1));
    assign frame_end = burst_end && head[DATA_W] && done_q[~sel_q];

    assign idle_o = (state_q == ARB) && (cnt_q == '0) && (closed_q == 2'b00) && (done_q == 2'b00);

    // Per-stream ready, eligibility and FIFO / frame bookkeeping.
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;
        closed_d = closed_q;
        done_d   = done_q;
        rdy      = '0;
        push     = '0;
        elig     = '0;
        for (int s = 0; s < 2; s++) begin
            // Ready is a function of state only: a closed frame blocks new input.
            rdy[s]  = !closed_q[s] && (cnt_q[s] < DEPTH_C);
            push[s] = in_vld[s] && rdy[s];
            elig[s] = !done_q[s] && ((cnt_q[s] >= BL_C) || (closed_q[s] && cnt_q[s] != '0));
            if (push[s])
                wptr_d[s] = (wptr_q[s] == PTR_MAX) ? '0 : wptr_q[s] + AW'(1);
            if (pop[s])
                rptr_d[s] = (rptr_q[s] == PTR_MAX) ? '0 : rptr_q[s] + AW'(1);
            if (push[s] && !pop[s])
                cnt_d[s] = cnt_q[s] + CW'(1);
            else if (!push[s] && pop[s])
                cnt_d[s] = cnt_q[s] - CW'(1);
            if (frame_end)
                closed_d[s] = 1'b0;
            else if (push[s] && in_last[s])
                closed_d[s] = 1'b1;
            if (frame_end)
                done_d[s] = 1'b0;
            else if (burst_end && fin_q && (sel_q == s[0]))
                done_d[s] = 1'b1;
        end
    end

    // Burst FSM: arbitrate, emit header, stream len payload words.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        fin_d   = fin_q;
        len_d   = len_q;
        beat_d  = beat_q;
        rr_d    = rr_q;
        pick    = rr_q;
        vld_o   = 1'b0;
        data_o  = '0;
        last_o  = 1'b0;
        unique case (state_q)
            ARB: begin
                if (elig != 2'b00) begin
                    pick    = (elig == 2'b11) ? rr_q : elig[1];
                    sel_d   = pick;
                    len_d   = (cnt_q[pick] >= BL_C) ? BL_C : cnt_q[pick];
                    fin_d   = closed_q[pick] && (cnt_q[pick] <= BL_C);
                    state_d = HDR;
                end
            end
            HDR: begin
                vld_o  = 1'b1;
                data_o = {sel_q, fin_q, hdr_len};
                if (rdy_i) begin
                    state_d = DATA;
                    beat_d  = len_q;
                end
            end
            DATA: begin
                vld_o  = 1'b1;
                data_o = head[DATA_W-1:0];
                last_o = head[DATA_W] && done_q[~sel_q];
                if (rdy_i) begin
                    beat_d = beat_q - CW'(1);
                    if (beat_q == CW'(1)) begin
                        state_d = ARB;
                        rr_d    = ~rr_q;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < 2; s++)
            if (push[s]) mem_q[s][wptr_q[s]] <= {in_last[s], in_data[s]};
    end

    // Control state; reset drops any buffered data and open burst.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            closed_q <= '0;
            done_q   <= '0;
            state_q  <= ARB;
            sel_q    <= 1'b0;
            fin_q    <= 1'b0;
            len_q    <= '0;
            beat_q   <= '0;
            rr_q     <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            closed_q <= closed_d;
            done_q   <= done_d;
            state_q  <= state_d;
            sel_q    <= sel_d;
            fin_q    <= fin_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            rr_q     <= rr_d;
        end
    end
endmodule
